// File: rtl/seq_detect_prog.sv
// Runtime-programmable serial bit-pattern detector with a registered match pulse.
// Optional saturating match counter is built only when SEQ_DETECT_CNT_EN is defined.
module seq_detect_prog #(
  parameter int               PAT_W   = 8,
  parameter int               LEN_W   = 4,
  parameter int               CNT_W   = 8,
  parameter logic [PAT_W-1:0] RST_PAT = PAT_W'(8'h2B),
  parameter int               RST_LEN = 6,
  parameter bit               RST_OVL = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x,
  input  logic             x_valid,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  output logic             z,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int FILL_W = $clog2(PAT_W + 1);

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
    if (int'(l) > PAT_W) return LEN_W'(PAT_W);
    return l;
  endfunction

  logic [PAT_W-1:0]  r_pat;
  logic [LEN_W-1:0]  r_len;
  logic              r_ovl;
  logic [PAT_W-1:0]  r_hist;
  logic [FILL_W-1:0] r_fill;
  logic              r_z;

  logic [PAT_W-1:0]  w_nh;
  logic [FILL_W-1:0] w_nf;
  logic [PAT_W-1:0]  w_mask;
  logic              w_hit;

  // Candidate next history; the oldest bit falls off the top, newest enters at bit 0.
  always_comb begin
    w_nh   = {r_hist[PAT_W-2:0], x};
    w_nf   = (int'(r_fill) >= PAT_W) ? FILL_W'(PAT_W) : r_fill + FILL_W'(1);
    w_mask = ~({PAT_W{1'b1}} << r_len);
    w_hit  = (r_len != '0) && (int'(w_nf) >= int'(r_len)) &&
             (((w_nh ^ r_pat) & w_mask) == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pat  <= RST_PAT;
      r_len  <= LEN_W'(RST_LEN);
      r_ovl  <= RST_OVL;
      r_hist <= '0;
      r_fill <= '0;
      r_z    <= 1'b0;
    end else if (cfg_load) begin
      // A coincident data bit is dropped; history is kept but marked stale via fill.
      r_pat  <= cfg_pattern;
      r_len  <= clamp_len(cfg_len);
      r_ovl  <= cfg_overlap;
      r_fill <= '0;
      r_z    <= 1'b0;
    end else if (x_valid) begin
      r_hist <= w_nh;
      r_z    <= w_hit;
      r_fill <= (w_hit && !r_ovl) ? '0 : w_nf;
    end else begin
      r_z    <= 1'b0;
    end
  end

  assign z = r_z;

`ifdef SEQ_DETECT_CNT_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst || cfg_load) r_cnt <= '0;
    else if (x_valid && w_hit) r_cnt <= sat_inc(r_cnt);
  end

  assign match_cnt = r_cnt;
`else
  assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_detect_prog.sv
// Self-checking bench for seq_detect_prog using a queue-based pattern model.
module tb_seq_detect_prog;

`ifdef SEQ_DETECT_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif
  localparam int PAT_W   = 8;
  localparam int CNT_MAX = 3;

  logic       clk, rst, x, x_valid, cfg_load, cfg_overlap, z;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic [1:0] match_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  seq_detect_prog #(.PAT_W(8), .LEN_W(4), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .x(x), .x_valid(x_valid), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .z(z), .match_cnt(match_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: bits received since the last clear, in arrival order.
  logic [7:0] m_pat;
  int         m_len;
  bit         m_ovl;
  bit         m_q[$];
  bit         ez;
  int         ecnt;

  function automatic bit model_hit();
    if (m_len == 0 || m_q.size() < m_len) return 1'b0;
    for (int i = 0; i < m_len; i++)
      if (m_q[m_q.size() - m_len + i] != m_pat[m_len - 1 - i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [1:0] exp_cnt();
    return CNT_EN ? 2'(ecnt) : 2'b00;
  endfunction

  task automatic step(input bit rs, input bit ld, input bit xv, input bit xb,
                      input logic [7:0] cp, input logic [3:0] cl, input bit co);
    bit h;
    rst = rs; cfg_load = ld; x_valid = xv; x = xb;
    cfg_pattern = cp; cfg_len = cl; cfg_overlap = co;
    @(posedge clk);
    #1;
    if (!rs) begin
      m_pat = 8'h2B; m_len = 6; m_ovl = 1'b1; m_q.delete(); ez = 1'b0; ecnt = 0;
    end else if (ld) begin
      m_pat = cp; m_len = (int'(cl) > PAT_W) ? PAT_W : int'(cl); m_ovl = co;
      m_q.delete(); ez = 1'b0; ecnt = 0;
    end else if (xv) begin
      m_q.push_back(xb);
      h = model_hit();
      ez = h;
      if (h && ecnt < CNT_MAX) ecnt++;
      if (h && !m_ovl) m_q.delete();
      if (m_q.size() > PAT_W) void'(m_q.pop_front());
    end else begin
      ez = 1'b0;
    end
    rst = 1'b1; cfg_load = 1'b0; x_valid = 1'b0;
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0);
  endtask

  task automatic send(input bit b);
    step(1'b1, 1'b0, 1'b1, b, 8'h00, 4'd0, 1'b0);
  endtask

  task automatic load(input logic [7:0] p, input logic [3:0] l, input bit o);
    step(1'b1, 1'b1, 1'b0, 1'b0, p, l, o);
  endtask

  // Sends a bit string (first bit = leftmost) and checks z after every edge.
  task automatic send_str(input string name, input string s);
    for (int i = 0; i < s.len(); i++) begin
      send(s[i] == "1");
      n_checks++;
      if (z !== ez) begin
        n_fail++;
        $display("FAIL %s z after bit %0d: got %b expected %b", name, i + 1, z, ez);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; x = 1'b1; x_valid = 1'b1; cfg_load = 1'b0;
    cfg_pattern = 8'h00; cfg_len = 4'd0; cfg_overlap = 1'b0;
    do_reset();
    do_reset();
    n_checks++;
    if (z !== 1'b0) begin n_fail++; $display("FAIL reset_z: got %b expected 0", z); end
    n_checks++;
    if (match_cnt !== 2'b00) begin
      n_fail++; $display("FAIL reset_cnt: got %0d expected 0", match_cnt);
    end
  endtask

  task automatic test_default_pattern();
    send_str("default", "101011");
    n_checks++;
    if (z !== 1'b1) begin n_fail++; $display("FAIL default_hit: got %b expected 1", z); end
    n_checks++;
    if (match_cnt !== exp_cnt()) begin
      n_fail++; $display("FAIL default_cnt: got %0d expected %0d", match_cnt, exp_cnt());
    end
  endtask

  task automatic test_overlap();
    do_reset();
    send_str("overlap", "10101101011");
    n_checks++;
    if (ecnt != 2 || match_cnt !== exp_cnt()) begin
      n_fail++; $display("FAIL overlap_cnt: got %0d expected %0d (model %0d)", match_cnt, exp_cnt(), ecnt);
    end
  endtask

  task automatic test_non_overlap();
    do_reset();
    load(8'h2B, 4'd6, 1'b0);
    send_str("nonoverlap", "10101101011");
    n_checks++;
    if (ecnt != 1 || match_cnt !== exp_cnt()) begin
      n_fail++; $display("FAIL nonoverlap_cnt: got %0d expected %0d (model %0d)", match_cnt, exp_cnt(), ecnt);
    end
  endtask

  task automatic test_gaps();
    string s = "110110";
    do_reset();
    load(8'b110, 4'd3, 1'b1);
    for (int i = 0; i < s.len(); i++) begin
      send(s[i] == "1");
      n_checks++;
      if (z !== ez) begin n_fail++; $display("FAIL gaps_bit z bit %0d: got %b expected %b", i + 1, z, ez); end
      for (int g = 0; g < 2; g++) begin
        step(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 4'd0, 1'b0);
        n_checks++;
        if (z !== 1'b0) begin n_fail++; $display("FAIL gaps_idle z bit %0d gap %0d: got %b expected 0", i + 1, g, z); end
      end
    end
    n_checks++;
    if (match_cnt !== exp_cnt()) begin
      n_fail++; $display("FAIL gaps_cnt: got %0d expected %0d", match_cnt, exp_cnt());
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    send_str("rstmid_pre", "10101");
    do_reset();
    send_str("rstmid_post", "1");
    n_checks++;
    if (z !== 1'b0 || match_cnt !== 2'b00) begin
      n_fail++; $display("FAIL rstmid: got z=%b cnt=%0d expected z=0 cnt=0", z, match_cnt);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    load(8'b11, 4'd2, 1'b1);
    send_str("sat", "111111");
    n_checks++;
    if (match_cnt !== (CNT_EN ? 2'd3 : 2'd0)) begin
      n_fail++; $display("FAIL sat_cnt: got %0d expected %0d", match_cnt, CNT_EN ? 3 : 0);
    end
  endtask

  task automatic test_priority();
    do_reset();
    send_str("prio_pre", "10101");
    step(1'b1, 1'b1, 1'b1, 1'b1, 8'h2B, 4'd6, 1'b1);
    n_checks++;
    if (z !== 1'b0) begin n_fail++; $display("FAIL prio_load_z: got %b expected 0", z); end
    send_str("prio_post", "1");
    n_checks++;
    if (z !== 1'b0) begin n_fail++; $display("FAIL prio_dropped: got %b expected 0", z); end
    load(8'hFF, 4'd0, 1'b1);
    for (int i = 0; i < 40; i++) begin
      send(1'($urandom));
      n_checks++;
      if (z !== 1'b0) begin n_fail++; $display("FAIL len0 z cycle %0d: got %b expected 0", i, z); end
    end
    load(8'hA5, 4'd15, 1'b1);
    send_str("clamp", "10100101");
    n_checks++;
    if (z !== 1'b1) begin n_fail++; $display("FAIL clamp_hit: got %b expected 1", z); end
  endtask

  task automatic test_random();
    int r;
    logic [3:0] cl;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 1) begin
        do_reset();
      end else if (r < 4) begin
        cl = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 4));
        load(8'($urandom), cl, 1'($urandom));
      end else begin
        step(1'b1, 1'b0, r < 80, 1'($urandom), 8'h00, 4'd0, 1'b0);
      end
      n_checks++;
      if (z !== ez || match_cnt !== exp_cnt()) begin
        n_fail++;
        $display("FAIL random cycle %0d: got z=%b cnt=%0d expected z=%b cnt=%0d", i, z, match_cnt, ez, exp_cnt());
      end
    end
  endtask

  initial begin
    test_reset();
    test_default_pattern();
    test_overlap();
    test_non_overlap();
    test_gaps();
    test_reset_mid();
    test_saturation();
    test_priority();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
